// File: rtl/instr_fetch_decode.sv
// Fetch stage: drives instruction-memory requests, latches the returned word into IR,
// and decodes its opcode into the immediate-format select for the sign-extender.
module instr_fetch_decode #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        valid,
  output logic [31:0] instruction,
  output logic [63:0] pc,
  output logic [2:0]  sel_type,
  output logic        illegal
);

  // Memory handshake: a word transfers on a rising edge where imem_req=1 and
  // imem_ready=1; imem_addr is held constant while imem_req=1 unless redirect or rst.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] fetch_pc_q, fetch_pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [63:0] pc_q, pc_d;
  logic [2:0]  sel_q, sel_d;
  logic        illegal_q, illegal_d;
  logic [2:0]  dec_sel;
  logic        dec_illegal;

  always_comb begin
    dec_sel     = 3'd5;
    dec_illegal = 1'b0;
    case (imem_rdata[6:0])
      7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111: dec_sel = 3'd0;
      7'b0100011:                                     dec_sel = 3'd1;
      7'b1100011:                                     dec_sel = 3'd2;
      7'b0110111, 7'b0010111:                         dec_sel = 3'd3;
      7'b1101111:                                     dec_sel = 3'd4;
      7'b0110011, 7'b0111011:                         dec_sel = 3'd5;
      default:                                        dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    sel_d      = sel_q;
    illegal_d  = illegal_q;
    if (redirect) begin
      // Any same-cycle memory response is dropped; only the fetch target changes.
      fetch_pc_d = redirect_pc & ~64'h3;
      valid_d    = 1'b0;
      state_d    = REQ;
    end else begin
      case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (imem_ready) begin
            instr_d    = imem_rdata;
            pc_d       = fetch_pc_q;
            sel_d      = dec_sel;
            illegal_d  = dec_illegal;
            valid_d    = 1'b1;
            fetch_pc_d = fetch_pc_q + 64'd4;
            state_d    = HOLD;
          end
        end
        HOLD: begin
          if (!stall) begin
            valid_d = 1'b0;
            state_d = REQ;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      valid_q    <= 1'b0;
      instr_q    <= 32'h0;
      pc_q       <= 64'h0;
      sel_q      <= 3'd5;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      sel_q      <= sel_d;
      illegal_q  <= illegal_d;
    end
  end

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = fetch_pc_q;
  assign valid       = valid_q;
  assign instruction = instr_q;
  assign pc          = pc_q;
  assign sel_type    = sel_q;
  assign illegal     = illegal_q;

endmodule

// File: doc/instr_fetch_decode.md
Name: instr_fetch_decode

Overview:
- Fetch stage of the 64-bit RISC-V core, directly upstream of the immediate sign-extender.
- Keeps the fetch PC and issues requests to instruction memory with a req/ready handshake.
- Latches the returned word into an instruction register (IR).
- Decodes the opcode into the 3-bit immediate-format select that the sign-extender consumes. The sign-extender reads the `instruction` and `sel_type` outputs of this block directly.

Parameters:
RESET_PC, 64'h0, fetch address loaded on reset; bits [1:0] must be 0.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  64  fetch address, valid while imem_req=1
imem_ready  in  1  memory returns imem_rdata this cycle (sampled only while imem_req=1)
imem_rdata  in  32  instruction word from memory
stall  in  1  downstream cannot accept the held instruction
redirect  in  1  branch/jump redirect request
redirect_pc  in  64  redirect target
valid  out  1  instruction, pc, sel_type, illegal are valid
instruction  out  32  IR contents, fed to sign-extender
pc  out  64  address of the instruction in IR
sel_type  out  3  immediate format select for the sign-extender
illegal  out  1  IR opcode is not a supported RV64I opcode

Behaviour:
- All outputs are registered, or are Moore decodes of the state register. No combinational path from any input to any output.
- State machine states:
  - IDLE: imem_req=0. Always moves to REQ next cycle.
  - REQ: imem_req=1, imem_addr=fetch_pc.
    - On imem_ready=1: IR<=imem_rdata, pc<=fetch_pc, sel_type/illegal<=decode(imem_rdata), valid<=1, fetch_pc<=fetch_pc+4, go to HOLD.
    - Otherwise stay in REQ with imem_addr unchanged.
  - HOLD: imem_req=0, valid=1, all outputs stable.
    - On a cycle with stall=0 the instruction is consumed: valid<=0, go to REQ.
    - With stall=1, stay in HOLD indefinitely.
- Decode uses opcode = imem_rdata[6:0]:
  - 0000011, 0010011, 0011011, 1100111 -> 0 (I)
  - 0100011 -> 1 (S)
  - 1100011 -> 2 (B)
  - 0110111, 0010111 -> 3 (U)
  - 1101111 -> 4 (J)
  - 0110011, 0111011 -> 5 (R, no immediate)
  - any other opcode -> sel_type=5, illegal=1. illegal=0 for all listed opcodes.
- Redirect has top priority in every state, including IDLE.
  - redirect=1 at an edge sets fetch_pc<={redirect_pc[63:2],2'b00}, valid<=0, state<=REQ.
  - A same-cycle imem_ready response is discarded: IR, pc and fetch_pc are not loaded from it.
  - A redirect in HOLD drops the held instruction even when stall=1.
- fetch_pc arithmetic is modulo 2^64: 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0.
- Reset has priority over redirect and everything else:
  - state<=IDLE, fetch_pc<=RESET_PC, valid<=0, instruction<=32'h0, pc<=64'h0, sel_type<=3'd5, illegal<=0.
  - imem_req=0 and imem_addr=RESET_PC from the first edge with rst=1.
  - Reset mid-request abandons the request; a memory response arriving on that edge is ignored.
- Latency and throughput:
  - Zero-wait memory (imem_ready high during the first REQ cycle): valid rises 1 cycle after imem_req rises.
  - Peak rate is one instruction every 2 cycles.
  - First imem_req is 1 cycle after rst deasserts.
- Memory contract: imem_addr does not change while imem_req=1 except via redirect or rst. imem_rdata is ignored when imem_ready=0.

Test Plan:
1. Reset, RESET_PC=0x1000, memory always ready returning 0xF0000013 -> imem_req high 1 cycle after rst drops, addr 0x1000. Next cycle: valid=1, pc=0x1000, instruction=0xF0000013, sel_type=0, illegal=0. Next fetch addr is 0x1004.
2. Feed opcodes 0100011, 1100011, 0110111, 1101111, 0110011, 0000000 -> sel_type 1, 2, 3, 4, 5, 5; illegal high only for 0000000.
3. Hold stall=1 for 5 cycles after valid -> valid, instruction, pc stable and imem_req=0 throughout. After stall drops: valid=0 next cycle and a request to pc+4.
4. imem_ready low for 3 REQ cycles -> imem_addr constant, valid=0. Capture occurs on the 4th cycle, when ready goes high.
5. redirect=1 with redirect_pc=0x2003 in the same cycle as imem_ready=1 -> response discarded, valid=0, next request addr 0x2000. Repeat with the block in HOLD and stall=1 -> held instruction dropped.
6. Redirect to 0xFFFF_FFFF_FFFF_FFFC, then consume -> next fetch addr 0x0. Assert rst during REQ -> valid=0, sel_type=5, and fetch restarts at RESET_PC.
